// File: rtl/clause_register_file.sv
// Clause register file: stores signed coefficient vectors with per-entry valid bits and
// streams the valid entries out in ascending index order over a valid/ready scan port.
module clause_register_file #(
    parameter int BIT_WIDTH_OF_INTEGER_VARIABLE = 4,
    parameter int NUMBER_OF_INTEGER_VARIABLES   = 3,
    parameter int MAX_NUMBER_OF_CLAUSES         = 8,
    parameter int CLAUSE_INDEX_WIDTH            = 3,
    localparam int CW = BIT_WIDTH_OF_INTEGER_VARIABLE * NUMBER_OF_INTEGER_VARIABLES
) (
    input  logic                          in_clk,
    input  logic                          in_reset,
    input  logic                          in_write_enable,
    input  logic [CLAUSE_INDEX_WIDTH-1:0] in_write_index,
    input  logic [CW-1:0]                 in_clause_coefficients,
    input  logic                          in_clear_all,
    input  logic                          in_scan_start,
    input  logic                          in_scan_ready,
    output logic                          out_scan_valid,
    output logic [CLAUSE_INDEX_WIDTH-1:0] out_scan_index,
    output logic [CW-1:0]                 out_scan_coefficients,
    output logic                          out_scan_last,
    output logic                          out_scan_busy,
    output logic                          out_scan_done,
    output logic [MAX_NUMBER_OF_CLAUSES-1:0] out_valid_mask,
    output logic [CLAUSE_INDEX_WIDTH:0]   out_clause_count,
    output logic                          out_write_error
);

    localparam int MW = (MAX_NUMBER_OF_CLAUSES > 1) ? $clog2(MAX_NUMBER_OF_CLAUSES) : 1;
    localparam logic [CLAUSE_INDEX_WIDTH:0] MAX_CLAUSES =
        (CLAUSE_INDEX_WIDTH+1)'(MAX_NUMBER_OF_CLAUSES);

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t                          state_q, state_d;
    logic [MAX_NUMBER_OF_CLAUSES-1:0] valid_q, valid_d;
    logic [CLAUSE_INDEX_WIDTH:0]     count_q, count_d;
    logic                            scan_valid_q, scan_valid_d;
    logic [CLAUSE_INDEX_WIDTH-1:0]   scan_index_q, scan_index_d;
    logic                            scan_last_q, scan_last_d;
    logic                            scan_done_q, scan_done_d;
    logic                            write_error_q, write_error_d;

    logic [CW-1:0]                   mem_q [MAX_NUMBER_OF_CLAUSES];

    logic                            write_req;
    logic                            write_ok;
    logic                            mem_we;
    logic [MW-1:0]                   mem_waddr;
    logic                            beat_xfer;

    logic [CLAUSE_INDEX_WIDTH-1:0]   first_idx;
    logic [CLAUSE_INDEX_WIDTH-1:0]   high_d;
    logic [CLAUSE_INDEX_WIDTH-1:0]   next_idx;
    logic [CLAUSE_INDEX_WIDTH-1:0]   high_q;

    assign write_req = in_write_enable & ~in_clear_all;
    assign write_ok  = write_req && ({1'b0, in_write_index} < MAX_CLAUSES) && (state_q == ST_IDLE);
    assign mem_we    = write_ok & ~in_reset;
    assign mem_waddr = in_write_index[MW-1:0];
    assign beat_xfer = scan_valid_q & in_scan_ready;

    always_comb begin
        valid_d = valid_q;
        count_d = count_q;
        if (in_clear_all) begin
            valid_d = '0;
            count_d = '0;
        end else if (write_ok) begin
            valid_d[mem_waddr] = 1'b1;
            if (!valid_q[mem_waddr]) begin
                count_d = count_q + (CLAUSE_INDEX_WIDTH+1)'(1);
            end
        end
    end

    // The first beat is chosen from the post-write mask so a write in the start cycle is included.
    always_comb begin
        first_idx = '0;
        next_idx  = '0;
        high_d    = '0;
        high_q    = '0;
        for (int i = MAX_NUMBER_OF_CLAUSES - 1; i >= 0; i--) begin
            if (valid_d[i]) first_idx = CLAUSE_INDEX_WIDTH'(i);
            if (valid_q[i] && (CLAUSE_INDEX_WIDTH'(i) > scan_index_q)) next_idx = CLAUSE_INDEX_WIDTH'(i);
        end
        for (int i = 0; i < MAX_NUMBER_OF_CLAUSES; i++) begin
            if (valid_d[i]) high_d = CLAUSE_INDEX_WIDTH'(i);
            if (valid_q[i]) high_q = CLAUSE_INDEX_WIDTH'(i);
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        scan_valid_d  = scan_valid_q;
        scan_index_d  = scan_index_q;
        scan_last_d   = scan_last_q;
        scan_done_d   = 1'b0;
        write_error_d = write_req & ~write_ok;

        if (in_clear_all) begin
            state_d      = ST_IDLE;
            scan_valid_d = 1'b0;
            scan_last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    scan_valid_d = 1'b0;
                    scan_last_d  = 1'b0;
                    if (in_scan_start) begin
                        if (count_q != '0) begin
                            state_d      = ST_SCAN;
                            scan_valid_d = 1'b1;
                            scan_index_d = first_idx;
                            scan_last_d  = (first_idx == high_d);
                        end else begin
                            scan_done_d = 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (beat_xfer) begin
                        if (scan_last_q) begin
                            state_d      = ST_IDLE;
                            scan_valid_d = 1'b0;
                            scan_last_d  = 1'b0;
                            scan_done_d  = 1'b1;
                        end else begin
                            scan_index_d = next_idx;
                            scan_last_d  = (next_idx == high_q);
                        end
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    scan_valid_d = 1'b0;
                    scan_last_d  = 1'b0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_q       <= ST_IDLE;
            valid_q       <= '0;
            count_q       <= '0;
            scan_valid_q  <= 1'b0;
            scan_index_q  <= '0;
            scan_last_q   <= 1'b0;
            scan_done_q   <= 1'b0;
            write_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            count_q       <= count_d;
            scan_valid_q  <= scan_valid_d;
            scan_index_q  <= scan_index_d;
            scan_last_q   <= scan_last_d;
            scan_done_q   <= scan_done_d;
            write_error_q <= write_error_d;
        end
    end

    // NOTE: storage has no reset; the valid bits alone decide what is readable.
    always_ff @(posedge in_clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= in_clause_coefficients;
        end
    end

    assign out_scan_valid        = scan_valid_q;
    assign out_scan_index        = scan_index_q;
    assign out_scan_coefficients = mem_q[scan_index_q[MW-1:0]];
    assign out_scan_last         = scan_last_q;
    assign out_scan_busy         = (state_q == ST_SCAN);
    assign out_scan_done         = scan_done_q;
    assign out_valid_mask        = valid_q;
    assign out_clause_count      = count_q;
    assign out_write_error       = write_error_q;

endmodule

// File: tb/tb_clause_register_file.sv
// Scoreboard bench for clause_register_file: stimulus pushes expected scan beats, a
// negedge monitor pops and compares every transferred beat and tracks pulse outputs.
module tb_clause_register_file;

    localparam int BW   = 4;
    localparam int NV   = 3;
    localparam int MAX  = 8;
    localparam int CIW  = 4;
    localparam int CW   = BW * NV;

    typedef struct {
        logic [CIW-1:0] idx;
        logic [CW-1:0]  coeff;
        logic           last;
    } beat_t;

    logic           clk = 1'b0;
    logic           in_reset;
    logic           in_write_enable;
    logic [CIW-1:0] in_write_index;
    logic [CW-1:0]  in_clause_coefficients;
    logic           in_clear_all;
    logic           in_scan_start;
    logic           in_scan_ready;
    logic           out_scan_valid;
    logic [CIW-1:0] out_scan_index;
    logic [CW-1:0]  out_scan_coefficients;
    logic           out_scan_last;
    logic           out_scan_busy;
    logic           out_scan_done;
    logic [MAX-1:0] out_valid_mask;
    logic [CIW:0]   out_clause_count;
    logic           out_write_error;

    int total = 0;
    int bad   = 0;

    beat_t exp_q[$];
    int    cycle       = 0;
    int    done_cnt    = 0;
    int    err_cnt     = 0;
    int    beat_cnt    = 0;
    bit    busy_seen   = 1'b0;
    int    first_beat  = -1;
    int    done_cycle  = -1;
    bit    hold_pending = 1'b0;
    beat_t held;

    always #5 clk = ~clk;

    clause_register_file #(
        .BIT_WIDTH_OF_INTEGER_VARIABLE(BW),
        .NUMBER_OF_INTEGER_VARIABLES(NV),
        .MAX_NUMBER_OF_CLAUSES(MAX),
        .CLAUSE_INDEX_WIDTH(CIW)
    ) dut (
        .in_clk(clk),
        .in_reset(in_reset),
        .in_write_enable(in_write_enable),
        .in_write_index(in_write_index),
        .in_clause_coefficients(in_clause_coefficients),
        .in_clear_all(in_clear_all),
        .in_scan_start(in_scan_start),
        .in_scan_ready(in_scan_ready),
        .out_scan_valid(out_scan_valid),
        .out_scan_index(out_scan_index),
        .out_scan_coefficients(out_scan_coefficients),
        .out_scan_last(out_scan_last),
        .out_scan_busy(out_scan_busy),
        .out_scan_done(out_scan_done),
        .out_valid_mask(out_valid_mask),
        .out_clause_count(out_clause_count),
        .out_write_error(out_write_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cycle++;
        if (out_scan_done === 1'b1) begin
            done_cnt++;
            done_cycle = cycle;
        end
        if (out_write_error === 1'b1) err_cnt++;
        if (out_scan_busy === 1'b1) busy_seen = 1'b1;
        if (out_scan_valid === 1'b1) begin
            if (hold_pending) begin
                check("hold_idx",   32'(out_scan_index),        32'(held.idx));
                check("hold_coeff", 32'(out_scan_coefficients), 32'(held.coeff));
                check("hold_last",  32'(out_scan_last),         32'(held.last));
            end
            if (in_scan_ready) begin
                hold_pending = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(out_scan_index), 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_idx",   32'(out_scan_index),        32'(e.idx));
                    check("beat_coeff", 32'(out_scan_coefficients), 32'(e.coeff));
                    check("beat_last",  32'(out_scan_last),         32'(e.last));
                end
                if (first_beat < 0) first_beat = cycle;
                beat_cnt++;
            end else begin
                hold_pending = 1'b1;
                held.idx   = out_scan_index;
                held.coeff = out_scan_coefficients;
                held.last  = out_scan_last;
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_clause(input logic [CIW-1:0] idx, input logic [CW-1:0] data);
        in_write_enable        = 1'b1;
        in_write_index         = idx;
        in_clause_coefficients = data;
        tick();
        in_write_enable        = 1'b0;
    endtask

    task automatic push_beat(input logic [CIW-1:0] idx, input logic [CW-1:0] coeff, input logic last);
        beat_t b;
        b.idx   = idx;
        b.coeff = coeff;
        b.last  = last;
        exp_q.push_back(b);
    endtask

    task automatic wait_done(input int snap, input int budget);
        int n;
        n = 0;
        while (done_cnt == snap && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == snap) check("done_timeout", 32'(done_cnt), 32'(snap + 1));
    endtask

    task automatic start_scan();
        in_scan_start = 1'b1;
        tick();
        in_scan_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap_done;
        int snap_err;

        in_reset               = 1'b1;
        in_write_enable        = 1'b0;
        in_write_index         = '0;
        in_clause_coefficients = '0;
        in_clear_all           = 1'b0;
        in_scan_start          = 1'b0;
        in_scan_ready          = 1'b1;
        tick();
        tick();
        in_reset = 1'b0;
        check("rst_mask",  32'(out_valid_mask),   32'h0);
        check("rst_count", 32'(out_clause_count), 32'd0);
        check("rst_valid", 32'(out_scan_valid),   32'd0);
        check("rst_busy",  32'(out_scan_busy),    32'd0);
        check("rst_done",  32'(out_scan_done),    32'd0);
        check("rst_err",   32'(out_write_error),  32'd0);

        // Three writes, then a full-speed scan.
        write_clause(4'd2, 12'h123);
        write_clause(4'd5, 12'h456);
        write_clause(4'd7, 12'h789);
        tick();
        check("w3_mask",  32'(out_valid_mask),   32'hA4);
        check("w3_count", 32'(out_clause_count), 32'd3);
        check("w3_err",   32'(err_cnt),          32'd0);

        push_beat(4'd2, 12'h123, 1'b0);
        push_beat(4'd5, 12'h456, 1'b0);
        push_beat(4'd7, 12'h789, 1'b1);
        snap_done  = done_cnt;
        first_beat = -1;
        beat_cnt   = 0;
        start_scan();
        check("first_beat_latency", 32'(out_scan_valid), 32'd1);
        check("first_beat_busy",    32'(out_scan_busy),  32'd1);
        wait_done(snap_done, 20);
        check("scan1_beats",      32'(beat_cnt),                32'd3);
        check("scan1_done_delay", 32'(done_cycle - first_beat), 32'd3);
        check("scan1_queue",      32'(exp_q.size()),            32'd0);
        tick();
        check("scan1_done_once",  32'(done_cnt - snap_done),    32'd1);
        check("scan1_idle_valid", 32'(out_scan_valid),          32'd0);
        check("scan1_idle_last",  32'(out_scan_last),           32'd0);
        check("scan1_idle_busy",  32'(out_scan_busy),           32'd0);

        // Rewrite index 5; scan with ready low for two cycles on that beat.
        write_clause(4'd5, 12'h5AB);
        tick();
        check("rw_count", 32'(out_clause_count), 32'd3);
        check("rw_mask",  32'(out_valid_mask),   32'hA4);
        push_beat(4'd2, 12'h123, 1'b0);
        push_beat(4'd5, 12'h5AB, 1'b0);
        push_beat(4'd7, 12'h789, 1'b1);
        snap_done = done_cnt;
        beat_cnt  = 0;
        start_scan();
        tick();
        check("stall_idx", 32'(out_scan_index), 32'd5);
        in_scan_ready = 1'b0;
        tick();
        tick();
        in_scan_ready = 1'b1;
        wait_done(snap_done, 20);
        check("scan2_beats", 32'(beat_cnt),     32'd3);
        check("scan2_queue", 32'(exp_q.size()), 32'd0);

        // Out-of-range write.
        snap_err = err_cnt;
        write_clause(4'd9, 12'hFFF);
        tick();
        tick();
        check("oor_err",   32'(err_cnt - snap_err),  32'd1);
        check("oor_mask",  32'(out_valid_mask),      32'hA4);
        check("oor_count", 32'(out_clause_count),    32'd3);

        // Write while a scan is stalled.
        push_beat(4'd2, 12'h123, 1'b0);
        push_beat(4'd5, 12'h5AB, 1'b0);
        push_beat(4'd7, 12'h789, 1'b1);
        in_scan_ready = 1'b0;
        snap_done = done_cnt;
        start_scan();
        snap_err = err_cnt;
        write_clause(4'd3, 12'h333);
        tick();
        tick();
        check("busy_err",   32'(err_cnt - snap_err), 32'd1);
        check("busy_mask",  32'(out_valid_mask),     32'hA4);
        check("busy_count", 32'(out_clause_count),   32'd3);
        in_scan_ready = 1'b1;
        wait_done(snap_done, 20);
        check("scan3_queue", 32'(exp_q.size()), 32'd0);
        tick();

        // Clear with a same-cycle write aborts a stalled scan.
        in_scan_ready = 1'b0;
        start_scan();
        tick();
        snap_done = done_cnt;
        snap_err  = err_cnt;
        in_clear_all           = 1'b1;
        in_write_enable        = 1'b1;
        in_write_index         = 4'd1;
        in_clause_coefficients = 12'hABC;
        tick();
        in_clear_all    = 1'b0;
        in_write_enable = 1'b0;
        check("clr_valid", 32'(out_scan_valid),   32'd0);
        check("clr_busy",  32'(out_scan_busy),    32'd0);
        check("clr_mask",  32'(out_valid_mask),   32'h0);
        check("clr_count", 32'(out_clause_count), 32'd0);
        tick();
        tick();
        check("clr_no_err",  32'(err_cnt - snap_err),   32'd0);
        check("clr_no_done", 32'(done_cnt - snap_done), 32'd0);
        in_scan_ready = 1'b1;

        // Start with an empty file.
        busy_seen = 1'b0;
        snap_done = done_cnt;
        start_scan();
        check("empty_done_pulse", 32'(out_scan_done), 32'd1);
        tick();
        tick();
        check("empty_busy_never", 32'(busy_seen),            32'd0);
        check("empty_done_once",  32'(done_cnt - snap_done), 32'd1);

        // Reset asserted mid-scan overrides everything.
        in_scan_ready = 1'b0;
        write_clause(4'd0, 12'h111);
        write_clause(4'd4, 12'h444);
        start_scan();
        tick();
        check("pre_rst_busy", 32'(out_scan_busy), 32'd1);
        in_reset        = 1'b1;
        in_write_enable = 1'b1;
        in_write_index  = 4'd9;
        in_scan_start   = 1'b1;
        tick();
        in_reset        = 1'b0;
        in_write_enable = 1'b0;
        in_scan_start   = 1'b0;
        check("mrst_valid", 32'(out_scan_valid),   32'd0);
        check("mrst_last",  32'(out_scan_last),    32'd0);
        check("mrst_busy",  32'(out_scan_busy),    32'd0);
        check("mrst_done",  32'(out_scan_done),    32'd0);
        check("mrst_err",   32'(out_write_error),  32'd0);
        check("mrst_mask",  32'(out_valid_mask),   32'h0);
        check("mrst_count", 32'(out_clause_count), 32'd0);
        in_scan_ready = 1'b1;
        tick();
        tick();
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clause_register_file.md
CLAUSE_REGISTER_FILE -- requirements
Module: clause_register_file

Interface
REQ-001 Parameter BIT_WIDTH_OF_INTEGER_VARIABLE, default 4: width of one signed coefficient.
REQ-002 Parameter NUMBER_OF_INTEGER_VARIABLES, default 3: coefficients per clause.
REQ-003 Parameter MAX_NUMBER_OF_CLAUSES, default 8: storage depth; legal range is 1 to 2**CLAUSE_INDEX_WIDTH.
REQ-004 Parameter CLAUSE_INDEX_WIDTH, default 3: width of all clause index ports.
REQ-005 Localparam CW = BIT_WIDTH_OF_INTEGER_VARIABLE*NUMBER_OF_INTEGER_VARIABLES is the clause vector width.
REQ-006 in_clk  input  1: sole clock, all state updates on rising edge.
REQ-007 in_reset  input  1: synchronous, active-high reset.
REQ-008 in_write_enable  input  1: write request this cycle.
REQ-009 in_write_index  input  CLAUSE_INDEX_WIDTH: target entry.
REQ-010 in_clause_coefficients  input  CW: clause data to write.
REQ-011 in_clear_all  input  1: invalidate all entries.
REQ-012 in_scan_start  input  1: request a read-out pass.
REQ-013 in_scan_ready  input  1: downstream accepts current scan beat.
REQ-014 out_scan_valid  output  1: scan beat present.
REQ-015 out_scan_index  output  CLAUSE_INDEX_WIDTH: index of presented clause.
REQ-016 out_scan_coefficients  output  CW: stored vector of out_scan_index.
REQ-017 out_scan_last  output  1: presented beat is final valid entry.
REQ-018 out_scan_busy  output  1: FSM in SCAN.
REQ-019 out_scan_done  output  1: one-cycle pass-complete pulse.
REQ-020 out_valid_mask  output  MAX_NUMBER_OF_CLAUSES: per-entry valid bits.
REQ-021 out_clause_count  output  CLAUSE_INDEX_WIDTH+1: number of valid entries.
REQ-022 out_write_error  output  1: one-cycle pulse for rejected write.

Function
REQ-023 Write accepted in IDLE when in_write_enable=1, in_clear_all=0, index < MAX: entry and its valid bit update at next edge; count +1 only if entry was previously invalid.
REQ-024 Write with index >= MAX, or any write while out_scan_busy=1, is ignored and pulses out_write_error next cycle.
REQ-025 in_clear_all=1 clears every valid bit and count at next edge, overrides a same-cycle write (no error pulse), and aborts an active scan; coefficient storage is not required to clear.
REQ-026 FSM states IDLE and SCAN only; IDLE->SCAN on in_scan_start with count>0 and in_clear_all=0; SCAN->IDLE on the accepted last beat or on clear.
REQ-027 in_scan_start in IDLE with count=0 stays IDLE and pulses out_scan_done next cycle; in_scan_start while in SCAN is ignored.
REQ-028 First beat: out_scan_valid=1 the cycle after start is accepted, presenting the lowest-index valid entry.
REQ-029 Beats present valid entries in strictly ascending index order, invalid entries skipped with no bubble; one beat per cycle when in_scan_ready stays high.
REQ-030 Beat transfers when out_scan_valid & in_scan_ready; while in_scan_ready=0, index, coefficients and last hold stable.
REQ-031 out_scan_last=1 exactly on the highest-index valid entry; its transfer returns to IDLE and pulses out_scan_done in the following cycle.
REQ-032 Scan abort by clear: out_scan_valid and out_scan_busy low the next cycle, no out_scan_done pulse.
REQ-033 out_scan_valid=0 and out_scan_last=0 whenever in IDLE; out_scan_index/coefficients are don't-care then.

Reset
REQ-034 in_reset=1 at an edge forces IDLE, out_valid_mask=0, out_clause_count=0, out_scan_valid=0, out_scan_last=0, out_scan_busy=0, out_scan_done=0, out_write_error=0, overriding all other inputs, including mid-scan.
REQ-035 Coefficient storage is not reset; no entry is readable until written after reset.

Verification
REQ-036 Reset, write idx 2,5,7 -> mask 0xA4, count 3; scan with ready=1 -> beats 2,5,7 on consecutive cycles, last on 7, done pulse one cycle later.
REQ-037 Rewrite idx 5 with new data -> count stays 3; scan shows new data at index 5.
REQ-038 Scan with ready low 2 cycles on beat idx 5 -> beat held stable 3 cycles, no loss or duplication.
REQ-039 Write idx 9 (MAX=8) and write during scan -> out_write_error pulses each time, mask and count unchanged.
REQ-040 Clear during scan with same-cycle write -> next cycle valid=0, busy=0, mask 0, count 0, no error, no done.
REQ-041 Scan start with count 0 -> busy never high, done pulses once; reset asserted mid-scan -> all outputs at reset values next cycle.
